// File: rtl/key_serial_rx.sv
// key_serial_rx: recovers fixed-length frames from an oversampled serial line and replays the data bits one per clock.
// Define KEY_RX_PARITY_EN to add an even-parity bit after the data; otherwise ParityErr is tied low.
//   state  | meaning
//   IDLE   | waiting for a falling edge on the synchronized line
//   START  | timing half a bit to the start-bit midpoint, rejecting glitches
//   DATA   | sampling data bits at their midpoints
//   PARITY | sampling the parity bit (KEY_RX_PARITY_EN only)
//   STOP   | sampling the stop bit and deciding emit / error
//   EMIT   | replaying data bits on InputKey with ValidCmd high
module key_serial_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic RxD,
  output logic InputKey,
  output logic ValidCmd,
  output logic FrameErr,
  output logic ParityErr,
  output logic Busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef KEY_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    EMIT
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_s, rx_p;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n, idx_inc;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 tc;
  logic                 key_n, valid_n, ferr_n, busy_n;
`ifdef KEY_RX_PARITY_EN
  logic                 pbad, pbad_n, perr_n;
`endif

  assign tc      = (cnt == '0);
  assign idx_inc = idx + 1'b1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_p     <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      InputKey <= 1'b0;
      ValidCmd <= 1'b0;
      FrameErr <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      rx_meta  <= RxD;
      rx_s     <= rx_meta;
      rx_p     <= rx_s;
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      sh       <= sh_n;
      InputKey <= key_n;
      ValidCmd <= valid_n;
      FrameErr <= ferr_n;
      Busy     <= busy_n;
    end
  end

`ifdef KEY_RX_PARITY_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pbad      <= 1'b0;
      ParityErr <= 1'b0;
    end else begin
      pbad      <= pbad_n;
      ParityErr <= perr_n;
    end
  end
`else
  assign ParityErr = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    key_n   = 1'b0;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef KEY_RX_PARITY_EN
    pbad_n  = pbad;
    perr_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_p && !rx_s) begin
          state_n = START;
          cnt_n   = CW'(OVERSAMPLE / 2 - 1);
`ifdef KEY_RX_PARITY_EN
          pbad_n  = 1'b0;
`endif
        end
      end
      START: begin
        if (!tc) begin
          cnt_n = cnt - 1'b1;
        end else if (!rx_s) begin
          state_n = DATA;
          cnt_n   = CW'(OVERSAMPLE - 1);
          idx_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (!tc) begin
          cnt_n = cnt - 1'b1;
        end else begin
          sh_n[idx] = rx_s;
          cnt_n     = CW'(OVERSAMPLE - 1);
          if (idx == IW'(DATA_BITS - 1)) begin
`ifdef KEY_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx_inc;
          end
        end
      end
`ifdef KEY_RX_PARITY_EN
      PARITY: begin
        if (!tc) begin
          cnt_n = cnt - 1'b1;
        end else begin
          pbad_n  = (^sh) ^ rx_s;
          state_n = STOP;
          cnt_n   = CW'(OVERSAMPLE - 1);
        end
      end
`endif
      STOP: begin
        if (!tc) begin
          cnt_n = cnt - 1'b1;
        end else if (!rx_s) begin
          ferr_n  = 1'b1;
          state_n = IDLE;
`ifdef KEY_RX_PARITY_EN
        end else if (pbad) begin
          perr_n  = 1'b1;
          state_n = IDLE;
`endif
        end else begin
          // First replayed bit is registered here so it appears the cycle after the stop sample.
          state_n = EMIT;
          idx_n   = '0;
          valid_n = 1'b1;
          key_n   = sh[0];
        end
      end
      EMIT: begin
        if (idx == IW'(DATA_BITS - 1)) begin
          state_n = IDLE;
        end else begin
          idx_n   = idx_inc;
          valid_n = 1'b1;
          key_n   = sh[idx_inc];
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_key_serial_rx.sv
// Bench for key_serial_rx: per-cycle expected-output timeline built from frame timing rules, plus directed literal checks.
module tb_key_serial_rx;
  localparam int OS   = 16;
  localparam int DB   = 4;
  localparam int MAXC = 20000;
`ifdef KEY_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic RxD = 1'b1;
  logic InputKey, ValidCmd, FrameErr, ParityErr, Busy;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int busy_cnt = 0;
  bit eb [MAXC];
  bit ev [MAXC];
  bit ek [MAXC];
  bit ef [MAXC];
  bit ep [MAXC];
  int vcyc [$];
  bit vkey [$];
  int fcyc [$];
  int pcyc [$];

  key_serial_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .Clk(Clk), .Reset(Reset), .RxD(RxD), .InputKey(InputKey),
    .ValidCmd(ValidCmd), .FrameErr(FrameErr), .ParityErr(ParityErr), .Busy(Busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic chk(string nm, int act, int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, expv);
    end
  endtask

  // Timeline model: start edge seen on the synchronized line 2 cycles after the fall is driven.
  function automatic void model_frame(int n, logic [DB-1:0] d, bit bad_stop, bit bad_par);
    int t0 = n + 2;
    int s  = t0 + OS / 2 + (DB + 1 + P) * OS;
    for (int c = t0 + 1; c <= s; c++) eb[c] = 1'b1;
    if (bad_stop) ef[s + 1] = 1'b1;
    else if (P == 1 && bad_par) ep[s + 1] = 1'b1;
    else begin
      for (int k = 0; k < DB; k++) begin
        eb[s + 1 + k] = 1'b1;
        ev[s + 1 + k] = 1'b1;
        ek[s + 1 + k] = d[k];
      end
    end
  endfunction

  task automatic idle(int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_cyc(int n);
    do @(negedge Clk); while (cyc < n);
  endtask

  task automatic send_frame(logic [DB-1:0] d, bit bad_stop, bit bad_par);
    model_frame(cyc, d, bad_stop, bad_par);
    RxD = 1'b0;
    idle(OS);
    for (int k = 0; k < DB; k++) begin
      RxD = d[k];
      idle(OS);
    end
    if (P == 1) begin
      RxD = (^d) ^ bad_par;
      idle(OS);
    end
    RxD = !bad_stop;
    idle(OS);
    RxD = 1'b1;
  endtask

  task automatic send_glitch(int len);
    int t0 = cyc + 2;
    for (int c = t0 + 1; c <= t0 + OS / 2; c++) eb[c] = 1'b1;
    RxD = 1'b0;
    idle(len);
    RxD = 1'b1;
    idle(12);
  endtask

  task automatic clear_q();
    vcyc.delete();
    vkey.delete();
    fcyc.delete();
    pcyc.delete();
  endtask

  task automatic chk_keys(string nm, int expbits, int expn);
    int act = 0;
    foreach (vkey[i]) act = (act << 1) | int'(vkey[i]);
    chk({nm, "_count"}, vcyc.size(), expn);
    chk({nm, "_bits"}, act, expbits);
  endtask

  always @(negedge Clk) begin
    if (!Reset && cyc < MAXC) begin
      chk("Busy", int'(Busy), int'(eb[cyc]));
      chk("ValidCmd", int'(ValidCmd), int'(ev[cyc]));
      chk("FrameErr", int'(FrameErr), int'(ef[cyc]));
      chk("ParityErr", int'(ParityErr), int'(ep[cyc]));
      if (ev[cyc]) chk("InputKey", int'(InputKey), int'(ek[cyc]));
    end
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      if (ValidCmd) begin
        vcyc.push_back(cyc);
        vkey.push_back(InputKey);
      end
      if (FrameErr) fcyc.push_back(cyc);
      if (ParityErr) pcyc.push_back(cyc);
      if (Busy) busy_cnt++;
    end
  end

  initial begin
    int n0;
    bit last_bad;
    #1 Reset = 1'b1;
    idle(3);
    chk("rst_InputKey", int'(InputKey), 0);
    chk("rst_ValidCmd", int'(ValidCmd), 0);
    chk("rst_FrameErr", int'(FrameErr), 0);
    chk("rst_ParityErr", int'(ParityErr), 0);
    chk("rst_Busy", int'(Busy), 0);
    #2 Reset = 1'b0;

    // Reset asserted in the middle of data bit 1 of a 1,0,1,0 frame.
    wait_cyc(20);
    model_frame(cyc, 4'b0101, 1'b0, 1'b0);
    RxD = 1'b0; idle(OS);
    RxD = 1'b1; idle(OS);
    RxD = 1'b0; idle(OS / 2);
    chk("busy_before_reset", int'(Busy), 1);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_InputKey", int'(InputKey), 0);
    chk("midrst_ValidCmd", int'(ValidCmd), 0);
    chk("midrst_FrameErr", int'(FrameErr), 0);
    chk("midrst_ParityErr", int'(ParityErr), 0);
    chk("midrst_Busy", int'(Busy), 0);
    for (int c = cyc; c < MAXC; c++) begin
      eb[c] = 1'b0; ev[c] = 1'b0; ek[c] = 1'b0; ef[c] = 1'b0; ep[c] = 1'b0;
    end
    RxD = 1'b1;
    idle(2);
    #2 Reset = 1'b0;
    clear_q();
    idle(200);
    chk("no_valid_after_reset", vcyc.size(), 0);

    // Good frame 1,0,1,0 starting at cycle 300: stop sample at 390 (+16 with parity).
    wait_cyc(300);
    clear_q();
    send_frame(4'b0101, 1'b0, 1'b0);
    idle(10);
    chk_keys("good_frame", 4'b1010, 4);
    if (vcyc.size() == 4) begin
      chk("good_first_valid", vcyc[0], 391 + 16 * P);
      chk("good_last_valid", vcyc[3], 394 + 16 * P);
    end
    chk("good_no_ferr", fcyc.size(), 0);

    // Glitch: low for 5 clocks.
    wait_cyc(500);
    clear_q();
    busy_cnt = 0;
    send_glitch(5);
    idle(10);
    chk("glitch_busy_cycles", busy_cnt, 8);
    chk("glitch_no_valid", vcyc.size(), 0);
    chk("glitch_no_ferr", fcyc.size(), 0);

    // Framing error on 1,1,0,0 at cycle 600, then a good frame.
    wait_cyc(600);
    clear_q();
    send_frame(4'b0011, 1'b1, 1'b0);
    chk("ferr_count", fcyc.size(), 1);
    if (fcyc.size() == 1) chk("ferr_cycle", fcyc[0], 691 + 16 * P);
    chk("ferr_no_valid", vcyc.size(), 0);
    idle(4);
    send_frame(4'b0101, 1'b0, 1'b0);
    idle(10);
    chk_keys("after_ferr", 4'b1010, 4);

    // Back-to-back frames 1,0,1,0 and 0,1,1,0.
    idle(20);
    clear_q();
    send_frame(4'b0101, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0);
    idle(10);
    chk_keys("back_to_back", 8'b10100110, 8);
    chk("b2b_no_ferr", fcyc.size(), 0);
    chk("b2b_no_perr", pcyc.size(), 0);

`ifdef KEY_RX_PARITY_EN
    idle(20);
    clear_q();
    n0 = cyc;
    send_frame(4'b0101, 1'b0, 1'b1);
    idle(10);
    chk("perr_count", pcyc.size(), 1);
    if (pcyc.size() == 1) chk("perr_cycle", pcyc[0], n0 + 107);
    chk("perr_no_valid", vcyc.size(), 0);
`endif

    // Randomized frames, glitches and gaps.
    idle(10);
    last_bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      int kind = $urandom_range(0, 9);
      int gap  = $urandom_range(0, 30);
      if (kind == 0) begin
        send_glitch($urandom_range(1, 6));
        last_bad = 1'b0;
      end else begin
        last_bad = ($urandom_range(0, 4) == 0);
        send_frame(4'($urandom), last_bad, ($urandom_range(0, 3) == 0));
      end
      if (last_bad && gap < 2) gap = 2;
      idle(gap);
    end
    idle(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
